// File: rtl/easiroc_readout_adc_model_if.sv
// Read-register and ADC side of the EASIROC readout model.
// The master drives the slow clocks and read-register controls; the slave returns the ADC codes.
interface easiroc_readout_adc_model_if;
  logic        clk_read;
  logic        rstb_read;
  logic        srin_read;
  logic        adc_clk_hg;
  logic        adc_clk_lg;
  logic [11:0] adc_data_hg;
  logic        adc_otr_hg;
  logic [11:0] adc_data_lg;
  logic        adc_otr_lg;
  logic        ch_valid;
  logic [4:0]  ch_index;
  logic        cycle_clk;
  logic        clk_out;
  logic        hold;

  modport master (
    output clk_read, rstb_read, srin_read, adc_clk_hg, adc_clk_lg,
    input  adc_data_hg, adc_otr_hg, adc_data_lg, adc_otr_lg,
    input  ch_valid, ch_index, cycle_clk, clk_out, hold
  );

  modport slave (
    input  clk_read, rstb_read, srin_read, adc_clk_hg, adc_clk_lg,
    output adc_data_hg, adc_otr_hg, adc_data_lg, adc_otr_lg,
    output ch_valid, ch_index, cycle_clk, clk_out, hold
  );
endinterface

// File: rtl/easiroc_readout_adc_model.sv
// EASIROC read-register channel mux feeding two AD9220 pipeline models (high/low gain),
// plus the cycle/hold generator. Slow clocks arrive as data and are edge-detected in clk.
module easiroc_readout_adc_model #(
  parameter int NCH          = 32,
  parameter int ADC_LATENCY  = 3,
  parameter int HG_BASE      = 100,
  parameter int HG_STEP      = 10,
  parameter int LG_BASE      = 50,
  parameter int LG_STEP      = 5,
  parameter int IDLE_CODE    = 0,
  parameter int CYCLE_PERIOD = 1000,
  parameter int HOLD_DELAY   = 100,
  parameter int HOLD_WIDTH   = 200
) (
  input logic                          clk,
  input logic                          rst_sys,
  easiroc_readout_adc_model_if.slave   bus
);

  localparam int CNTW = $clog2(CYCLE_PERIOD);

  // Bit positions inside the synchroniser vectors.
  localparam int S_CLK_READ = 0;
  localparam int S_ADC_HG   = 1;
  localparam int S_ADC_LG   = 2;
  localparam int S_RSTB     = 3;
  localparam int S_SRIN     = 4;

  // {otr, code[11:0]}; saturates at full scale like the real converter.
  function automatic logic [12:0] adc_code(
    input logic        valid,
    input logic [4:0]  idx,
    input logic [15:0] base,
    input logic [15:0] step
  );
    logic [15:0] raw;
    raw = base + step * {11'd0, idx};
    if (!valid) begin
      adc_code = {1'b0, 12'(IDLE_CODE)};
    end else if (raw > 16'd4095) begin
      adc_code = {1'b1, 12'hFFF};
    end else begin
      adc_code = {1'b0, raw[11:0]};
    end
  endfunction

  logic [4:0]      async_in_s;
  logic [4:0]      meta_q;
  logic [4:0]      sync_q;
  logic [2:0]      prev_q;
  logic [2:0]      rise_s;

  logic [NCH-1:0]  sr_q;
  logic [NCH-1:0]  sr_d;
  logic            ch_valid_s;
  logic [4:0]      ch_index_s;
  logic [12:0]     code_hg_s;
  logic [12:0]     code_lg_s;

  logic [12:0]     pipe_hg_q [ADC_LATENCY];
  logic [12:0]     pipe_lg_q [ADC_LATENCY];

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            cycle_clk_q;
  logic            cycle_clk_d;
  logic            hold_q;
  logic            hold_d;
  logic            clk_out_q;

  assign async_in_s = {bus.srin_read, bus.rstb_read, bus.adc_clk_lg, bus.adc_clk_hg, bus.clk_read};
  assign rise_s     = sync_q[2:0] & ~prev_q;

  // Two-flop synchronisers, plus the previous value of each sampled clock for edge detection
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      meta_q <= 5'b0;
      sync_q <= 5'b0;
      prev_q <= 3'b0;
    end else begin
      meta_q <= async_in_s;
      sync_q <= meta_q;
      prev_q <= sync_q[2:0];
    end
  end

  // Read-register next state; an active clear wins over a coincident shift
  always_comb begin
    sr_d = sr_q;
    if (!sync_q[S_RSTB]) begin
      sr_d = {NCH{1'b0}};
    end else if (rise_s[S_CLK_READ]) begin
      sr_d = {sr_q[NCH-2:0], sync_q[S_SRIN]};
    end else begin
      sr_d = sr_q;
    end
  end

  // Read-register state
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      sr_q <= {NCH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  // Lowest set bit selects the channel; scanning downward lets the lowest index win
  always_comb begin
    ch_valid_s = 1'b0;
    ch_index_s = 5'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (sr_q[i]) begin
        ch_valid_s = 1'b1;
        ch_index_s = 5'(i);
      end else begin
        ch_valid_s = ch_valid_s;
      end
    end
  end

  assign code_hg_s = adc_code(ch_valid_s, ch_index_s, 16'(HG_BASE), 16'(HG_STEP));
  assign code_lg_s = adc_code(ch_valid_s, ch_index_s, 16'(LG_BASE), 16'(LG_STEP));

  // High-gain converter pipeline, advanced only by its own ADC clock edge
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      for (int i = 0; i < ADC_LATENCY; i++) begin
        pipe_hg_q[i] <= 13'd0;
      end
    end else if (rise_s[S_ADC_HG]) begin
      pipe_hg_q[0] <= code_hg_s;
      for (int i = 1; i < ADC_LATENCY; i++) begin
        pipe_hg_q[i] <= pipe_hg_q[i-1];
      end
    end
  end

  // Low-gain converter pipeline, independent of the high-gain one
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      for (int i = 0; i < ADC_LATENCY; i++) begin
        pipe_lg_q[i] <= 13'd0;
      end
    end else if (rise_s[S_ADC_LG]) begin
      pipe_lg_q[0] <= code_lg_s;
      for (int i = 1; i < ADC_LATENCY; i++) begin
        pipe_lg_q[i] <= pipe_lg_q[i-1];
      end
    end
  end

  // Cycle counter next state; outputs decode the next count so they line up with cnt_q
  always_comb begin
    if (cnt_q == CNTW'(CYCLE_PERIOD - 1)) begin
      cnt_d = {CNTW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNTW'(1);
    end
    cycle_clk_d = (int'(cnt_d) < (CYCLE_PERIOD / 2));
    hold_d      = (int'(cnt_d) >= HOLD_DELAY) && (int'(cnt_d) < (HOLD_DELAY + HOLD_WIDTH));
  end

  // Cycle generator registers
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      cnt_q       <= {CNTW{1'b0}};
      cycle_clk_q <= 1'b0;
      hold_q      <= 1'b0;
      clk_out_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cycle_clk_q <= cycle_clk_d;
      hold_q      <= hold_d;
      clk_out_q   <= ~clk_out_q;
    end
  end

  assign bus.adc_data_hg = pipe_hg_q[ADC_LATENCY-1][11:0];
  assign bus.adc_otr_hg  = pipe_hg_q[ADC_LATENCY-1][12];
  assign bus.adc_data_lg = pipe_lg_q[ADC_LATENCY-1][11:0];
  assign bus.adc_otr_lg  = pipe_lg_q[ADC_LATENCY-1][12];
  assign bus.ch_valid    = ch_valid_s;
  assign bus.ch_index    = ch_index_s;
  assign bus.cycle_clk   = cycle_clk_q;
  assign bus.hold        = hold_q;
  assign bus.clk_out     = clk_out_q;

endmodule

// File: tb/tb_easiroc_readout_adc_model.sv
// Bench for easiroc_readout_adc_model: directed scenarios plus random traffic, checked
// against a token/queue reference model. A second instance uses HG_BASE=4000 for saturation.
module tb_easiroc_readout_adc_model;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_sys;
  logic clk_read_v, rstb_v, srin_v, ahg_v, alg_v;

  always #10 clk = ~clk;

  easiroc_readout_adc_model_if bus_a ();
  easiroc_readout_adc_model_if bus_s ();

  assign bus_a.clk_read   = clk_read_v;
  assign bus_a.rstb_read  = rstb_v;
  assign bus_a.srin_read  = srin_v;
  assign bus_a.adc_clk_hg = ahg_v;
  assign bus_a.adc_clk_lg = alg_v;
  assign bus_s.clk_read   = clk_read_v;
  assign bus_s.rstb_read  = rstb_v;
  assign bus_s.srin_read  = srin_v;
  assign bus_s.adc_clk_hg = ahg_v;
  assign bus_s.adc_clk_lg = alg_v;

  easiroc_readout_adc_model u_dut (.clk(clk), .rst_sys(rst_sys), .bus(bus_a));
  easiroc_readout_adc_model #(.HG_BASE(4000)) u_dut_sat (.clk(clk), .rst_sys(rst_sys), .bus(bus_s));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: read register as a token vector, converters as queues of sampled codes.
  logic [31:0] sr_m;
  int q_hg[$];
  int q_lg[$];
  int q_sat[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int lowest(input logic [31:0] sr);
    for (int i = 0; i < 32; i++) if (sr[i]) return i;
    return 0;
  endfunction

  // Encoded as otr*4096 + code.
  function automatic int ref_code(input logic [31:0] sr, input int base, input int step);
    int raw;
    if (sr == 32'd0) return 0;
    raw = base + step * lowest(sr);
    return (raw > 4095) ? (4096 + 4095) : raw;
  endfunction

  function automatic int pipe_out(input int q[$]);
    return (q.size() >= LAT) ? q[LAT-1] : 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    clk_read_v = 1'b0; rstb_v = 1'b1; srin_v = 1'b0; ahg_v = 1'b0; alg_v = 1'b0;
    sr_m = 32'd0;
    q_hg.delete(); q_lg.delete(); q_sat.delete();
    repeat (3) @(negedge clk);
    rst_sys = 1'b0;
  endtask

  task automatic read_edge(input bit din);
    srin_v = din;
    wait_cyc(3);
    clk_read_v = 1'b1;
    sr_m = rstb_v ? {sr_m[30:0], din} : 32'd0;
    wait_cyc(4);
    clk_read_v = 1'b0;
    wait_cyc(4);
  endtask

  task automatic adc_edge(input bit hg, input bit lg);
    if (hg) begin
      q_hg.push_front(ref_code(sr_m, 100, 10));
      q_sat.push_front(ref_code(sr_m, 4000, 10));
      if (q_hg.size() > LAT) void'(q_hg.pop_back());
      if (q_sat.size() > LAT) void'(q_sat.pop_back());
      ahg_v = 1'b1;
    end
    if (lg) begin
      q_lg.push_front(ref_code(sr_m, 50, 5));
      if (q_lg.size() > LAT) void'(q_lg.pop_back());
      alg_v = 1'b1;
    end
    wait_cyc(4);
    ahg_v = 1'b0;
    alg_v = 1'b0;
    wait_cyc(4);
  endtask

  task automatic rstb_pulse();
    rstb_v = 1'b0;
    sr_m = 32'd0;
    wait_cyc(3);
    rstb_v = 1'b1;
    wait_cyc(4);
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "/ch_valid"}, int'(bus_a.ch_valid), int'(sr_m != 32'd0));
    check_val({tag, "/ch_index"}, int'(bus_a.ch_index), lowest(sr_m));
    check_val({tag, "/hg"}, int'({bus_a.adc_otr_hg, bus_a.adc_data_hg}), pipe_out(q_hg));
    check_val({tag, "/lg"}, int'({bus_a.adc_otr_lg, bus_a.adc_data_lg}), pipe_out(q_lg));
    check_val({tag, "/sat_hg"}, int'({bus_s.adc_otr_hg, bus_s.adc_data_hg}), pipe_out(q_sat));
    check_val({tag, "/sat_lg"}, int'({bus_s.adc_otr_lg, bus_s.adc_data_lg}), pipe_out(q_lg));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "/outs"},
              int'({bus_a.adc_data_hg, bus_a.adc_otr_hg, bus_a.adc_data_lg, bus_a.adc_otr_lg,
                    bus_a.ch_valid, bus_a.ch_index, bus_a.cycle_clk, bus_a.clk_out, bus_a.hold}), 0);
  endtask

  initial begin
    int err_cc, err_hold, err_co, hold_hi, hold_rises, km;
    logic hold_prev;

    rst_sys = 1'b1;
    clk_read_v = 1'b0; rstb_v = 1'b1; srin_v = 1'b0; ahg_v = 1'b0; alg_v = 1'b0;
    sr_m = 32'd0;
    #35;
    check_zero_outputs("reset");

    // Free-running cycle generator: at sample k after reset the counter is k mod 1000.
    do_reset();
    err_cc = 0; err_hold = 0; err_co = 0; hold_hi = 0; hold_rises = 0; hold_prev = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      km = k % 1000;
      if (bus_a.cycle_clk !== (km < 500)) err_cc++;
      if (bus_a.hold !== ((km >= 100) && (km < 300))) err_hold++;
      if (bus_a.clk_out !== 1'(k % 2)) err_co++;
      if (bus_s.hold !== bus_a.hold) err_hold++;
      if (bus_a.hold === 1'b1) hold_hi++;
      if (bus_a.hold === 1'b1 && hold_prev === 1'b0) hold_rises++;
      hold_prev = bus_a.hold;
    end
    check_val("cycle_clk_shape", err_cc, 0);
    check_val("hold_shape", err_hold, 0);
    check_val("clk_out_shape", err_co, 0);
    check_val("hold_high_cycles", hold_hi, 400);
    check_val("hold_pulses", hold_rises, 2);

    // Empty register gives the idle code.
    do_reset();
    for (int i = 0; i < 5; i++) read_edge(1'b0);
    check_val("idle/ch_valid", int'(bus_a.ch_valid), 0);
    for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b0);
    check_val("idle/hg", int'(bus_a.adc_data_hg), 0);
    check_val("idle/otr_hg", int'(bus_a.adc_otr_hg), 0);
    check_all("idle");

    // Token shifted four places lands on channel 4.
    read_edge(1'b1);
    for (int i = 0; i < 4; i++) read_edge(1'b0);
    check_val("ch4/index", int'(bus_a.ch_index), 4);
    for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b1);
    check_val("ch4/hg", int'(bus_a.adc_data_hg), 140);
    check_val("ch4/lg", int'(bus_a.adc_data_lg), 70);
    check_all("ch4");

    // Walk a single token through the whole register and off the end.
    do_reset();
    for (int pos = 0; pos <= 32; pos++) begin
      read_edge(pos == 0);
      for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b1);
      check_all($sformatf("walk%0d", pos));
      if (pos < 32) begin
        check_val($sformatf("walk%0d/hg_c", pos), int'(bus_a.adc_data_hg), 100 + 10 * pos);
      end else begin
        check_val("walk_off/ch_valid", int'(bus_a.ch_valid), 0);
      end
      if (pos == 9) begin
        check_val("sat9/hg", int'(bus_s.adc_data_hg), 4090);
        check_val("sat9/otr", int'(bus_s.adc_otr_hg), 0);
      end
      if (pos == 10) begin
        check_val("sat10/hg", int'(bus_s.adc_data_hg), 4095);
        check_val("sat10/otr", int'(bus_s.adc_otr_hg), 1);
      end
    end

    // Clear coinciding with a read-clock edge leaves the register empty.
    do_reset();
    read_edge(1'b1);
    for (int i = 0; i < 3; i++) read_edge(1'b0);
    check_val("clr/pre_index", int'(bus_a.ch_index), 3);
    srin_v = 1'b1;
    wait_cyc(3);
    rstb_v = 1'b0;
    clk_read_v = 1'b1;
    wait_cyc(2);
    clk_read_v = 1'b0;
    wait_cyc(2);
    rstb_v = 1'b1;
    sr_m = 32'd0;
    srin_v = 1'b0;
    wait_cyc(4);
    check_val("clr/ch_valid", int'(bus_a.ch_valid), 0);
    for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b1);
    check_val("clr/hg", int'(bus_a.adc_data_hg), 0);
    check_val("clr/lg", int'(bus_a.adc_data_lg), 0);
    check_all("clr");

    // Asynchronous reset in the middle of traffic clears outputs at once.
    read_edge(1'b1);
    for (int i = 0; i < 5; i++) read_edge(1'b0);
    for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b1);
    check_val("midrst/pre_hg", int'(bus_a.adc_data_hg), 150);
    @(posedge clk);
    #3;
    rst_sys = 1'b1;
    #2;
    check_zero_outputs("midrst");
    do_reset();

    // Random traffic against the reference model.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0, 1:    read_edge($urandom_range(0, 3) == 0);
        2:       adc_edge(1'b1, 1'b0);
        3:       adc_edge($urandom_range(0, 1) == 1, 1'b1);
        default: rstb_pulse();
      endcase
      check_all($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/easiroc_readout_adc_model.md
Name: easiroc_readout_adc_model

Overview:
- Behavioural model of one EASIROC read-register channel multiplexer feeding two AD9220 12-bit ADCs (high gain and low gain), plus a CCC-style cycle/hold generator.
- Everything runs in the 50 MHz `clk` domain. The slow `clk_read` and ADC clocks enter as sampled data inputs.
- Used in the system bench to return deterministic per-channel ADC codes to the readout firmware.

Parameters:
- NCH, 32, read-register length (channel count).
- ADC_LATENCY, 3, AD9220 pipeline depth in ADC-clock rising edges.
- HG_BASE, 100, high-gain code for channel 0.
- HG_STEP, 10, high-gain code increment per channel.
- LG_BASE, 50, low-gain code for channel 0.
- LG_STEP, 5, low-gain code increment per channel.
- IDLE_CODE, 0, analog code when no channel is selected.
- CYCLE_PERIOD, 1000, cycle length in `clk` cycles.
- HOLD_DELAY, 100, cycle count at which `hold` rises.
- HOLD_WIDTH, 200, `hold` high duration in `clk` cycles.

Ports:
- clk  in  1  50 MHz system clock; all flops use its rising edge.
- rst_sys  in  1  asynchronous, active-high reset.
- clk_read  in  1  EASIROC read-register shift clock.
- rstb_read  in  1  active-low read-register clear.
- srin_read  in  1  read-register serial input (token).
- adc_clk_hg  in  1  high-gain ADC sample clock.
- adc_clk_lg  in  1  low-gain ADC sample clock.
- adc_data_hg  out  12  high-gain ADC code; bit 11 is the MSB.
- adc_otr_hg  out  1  high-gain out-of-range flag.
- adc_data_lg  out  12  low-gain ADC code.
- adc_otr_lg  out  1  low-gain out-of-range flag.
- ch_valid  out  1  a channel is currently selected.
- ch_index  out  5  index of the selected channel.
- cycle_clk  out  1  cycle clock.
- clk_out  out  1  `clk` divided by 2.
- hold  out  1  hold pulse.

Behaviour:
- Reset (`rst_sys` high, asynchronous):
  - Shift register, synchronisers, pipelines and cycle counter are all 0.
  - All outputs are 0: data, OTR flags, `ch_valid`, `ch_index`, `cycle_clk`, `clk_out`, `hold`.
- Input sampling:
  - `clk_read`, `adc_clk_hg`, `adc_clk_lg`, `rstb_read` and `srin_read` each pass through a 2-flop synchroniser.
  - A rising edge is detected when the synchronised value is 1 and its previous registered value is 0.
  - Input clocks must have high and low phases of at least 2 `clk` periods.
- Read register `sr[NCH-1:0]`:
  - When synchronised `rstb_read` = 0, `sr` clears. Clear has priority over shift.
  - Otherwise, on a detected `clk_read` rising edge, `sr` <= {sr[NCH-2:0], srin_read}.
  - The synchronised `srin_read` value is the one shifted in.
- Channel select (combinational from `sr`):
  - `ch_index` is the lowest set bit index and `ch_valid` = 1.
  - If `sr` is 0, `ch_valid` = 0 and `ch_index` = 0.
  - After NCH further shifts a single token falls off the end and `ch_valid` returns to 0.
- Analog code:
  - With a channel selected, raw_hg = HG_BASE + HG_STEP*ch_index, computed at 16 bits. raw_lg uses LG_BASE and LG_STEP the same way.
  - If raw > 4095, the code is 4095 and OTR = 1; otherwise code = raw and OTR = 0.
  - With no channel selected, the code is IDLE_CODE and OTR = 0.
- AD9220 pipeline, one per gain:
  - On each detected rising edge of that gain's ADC clock, {code, otr} enters stage 0 and all stages shift by one.
  - `adc_data`/`adc_otr` come from stage ADC_LATENCY-1.
  - The value sampled at edge N therefore appears at the output after edge N+ADC_LATENCY-1 has been detected, i.e. it is visible in the following cycle.
  - Outputs change only on that gain's ADC-clock edges. The two gains are independent.
- Cycle generator:
  - Counter `cnt` runs 0..CYCLE_PERIOD-1 and wraps to 0.
  - `cycle_clk` is registered high while `cnt` < CYCLE_PERIOD/2.
  - `hold` is registered high while HOLD_DELAY <= `cnt` < HOLD_DELAY+HOLD_WIDTH.
  - `clk_out` toggles every `clk` cycle.
- Simultaneous events:
  - A `clk_read` edge coinciding with `rstb_read` low yields `sr` = 0.
  - An ADC edge in the same cycle as a `sr` change samples the code computed from the pre-update `sr`, since the code is derived from the registered `sr`.

Test Plan:
- Reset, then 5 `clk_read` edges with `srin_read` = 0 → `ch_valid` = 0; after 3 `adc_clk_hg` edges, `adc_data_hg` = 0 and `adc_otr_hg` = 0.
- `srin_read` = 1 for one `clk_read` edge, then 0, then 4 more edges → `ch_index` = 4. After 3 further ADC edges, `adc_data_hg` = 140 and `adc_data_lg` = 70.
- Walk the token 32 edges → `ch_index` steps 0..31 (HG codes 100..410); the 33rd edge drops `ch_valid` to 0.
- HG_BASE = 4000, HG_STEP = 10, select channel 10 → `adc_data_hg` = 4095, `adc_otr_hg` = 1. Channel 9 → 4090, OTR = 0.
- Token at channel 3, then `rstb_read` low for 4 `clk` cycles while `clk_read` toggles → `sr` = 0, `ch_valid` = 0, codes return to 0 after 3 ADC edges. Asserting `rst_sys` mid-pipeline clears outputs immediately.
- Free-run 2000 `clk` cycles after reset:
  - `hold` is high for exactly 200 cycles starting at `cnt` 100, twice.
  - `cycle_clk` has a 1000-cycle period at 50% duty.
  - `clk_out` has a 2-cycle period.
